// File: rtl/board_mem_tester.sv
// -----------------------------------------------------------------------------
// board_mem_tester
//
// On-board SRAM self-test engine. On start it writes a pattern to every tested
// word of every bank, reads everything back in the same order, and stops on the
// first mismatch. It reports pass/fail, the failing location and status LEDs.
// The pin wrapper owns the tristate buffers; this block only requests a drive
// through ram_data_oe.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   start             level-sampled test request (ignored while busy)
//   mode              pattern select, captured at test start
//   ram_addr          word address (bits above TEST_ADDR_WIDTH are 0)
//   ram_data_o        write data; ram_data_oe = 1 asks the wrapper to drive it
//   ram_data_i        read data from the bus
//   ram_ce_n          per-bank chip enable, active-low, at most one low
//   ram_oe_n/ram_we_n output / write enable, active-low
//   busy, done, pass  test status (pass is valid while done = 1)
//   fail_bank/addr/data  location and value read at the first mismatch
//   leds              status display
// -----------------------------------------------------------------------------
module board_mem_tester #(
   parameter int ADDR_WIDTH      = 20,
   parameter int DATA_WIDTH      = 32,
   parameter int NUM_BANKS       = 2,
   parameter int TEST_ADDR_WIDTH = 20,
   parameter int WAIT_CYCLES     = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [1:0]                 mode,
   output logic [ADDR_WIDTH-1:0]      ram_addr,
   output logic [DATA_WIDTH-1:0]      ram_data_o,
   output logic                       ram_data_oe,
   input  logic [DATA_WIDTH-1:0]      ram_data_i,
   output logic [NUM_BANKS-1:0]       ram_ce_n,
   output logic                       ram_oe_n,
   output logic                       ram_we_n,
   output logic                       busy,
   output logic                       done,
   output logic                       pass,
   output logic [2:0]                 fail_bank,
   output logic [TEST_ADDR_WIDTH-1:0] fail_addr,
   output logic [DATA_WIDTH-1:0]      fail_data,
   output logic [15:0]                leds
);

   localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD, S_RD_WAIT, S_DONE
   } state_t;

   state_t                     state_q, state_d;
   logic [2:0]                 bank_q, bank_d;
   logic [TEST_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [1:0]                 mode_q, mode_d;
   logic                       pass_d;
   logic [2:0]                 fail_bank_d;
   logic [TEST_ADDR_WIDTH-1:0] fail_addr_d;
   logic [DATA_WIDTH-1:0]      fail_data_d;

   // Next values of the SRAM pins; registered so strobes never glitch.
   logic [ADDR_WIDTH-1:0]      ram_addr_d;
   logic [DATA_WIDTH-1:0]      ram_data_o_d;
   logic                       ram_data_oe_d;
   logic [NUM_BANKS-1:0]       ram_ce_n_d;
   logic                       ram_oe_n_d;
   logic                       ram_we_n_d;

   logic last_addr, last_bank, wrap_all, wr_next, rd_next;

   // P(b,a): base pattern for the address, inverted on odd banks so that
   // aliased banks read back the complement of what they expect.
   function automatic logic [DATA_WIDTH-1:0] pattern(
      input logic [1:0]                 m,
      input logic [2:0]                 b,
      input logic [TEST_ADDR_WIDTH-1:0] a
   );
      logic [DATA_WIDTH-1:0] base;
      case (m)
         2'd0:    base = DATA_WIDTH'(a);
         2'd1:    base = a[0] ? {(DATA_WIDTH/2){2'b10}} : {(DATA_WIDTH/2){2'b01}};
         2'd2:    base = DATA_WIDTH'(1) << (a % DATA_WIDTH);
         default: base = ~DATA_WIDTH'(a);
      endcase
      return base ^ {DATA_WIDTH{b[0]}};
   endfunction

   assign last_addr = (addr_q == '1);
   assign last_bank = (bank_q == 3'(NUM_BANKS - 1));
   assign wrap_all  = last_addr && last_bank;

   // NOTE: every signal gets its default before the case so no path leaves
   // one unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d     = state_q;
      bank_d      = bank_q;
      addr_d      = addr_q;
      cnt_d       = cnt_q;
      mode_d      = mode_q;
      pass_d      = pass;
      fail_bank_d = fail_bank;
      fail_addr_d = fail_addr;
      fail_data_d = fail_data;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d     = S_WR_SETUP;
               mode_d      = mode;
               bank_d      = '0;
               addr_d      = '0;
               pass_d      = 1'b0;
               fail_bank_d = '0;
               fail_addr_d = '0;
               fail_data_d = '0;
            end
         end
         S_WR_SETUP: begin
            state_d = S_WR_PULSE;
            cnt_d   = '0;
         end
         S_WR_PULSE: begin
            if (cnt_q == CNT_W'(WAIT_CYCLES - 1)) state_d = S_WR_HOLD;
            else                                  cnt_d   = cnt_q + 1'b1;
         end
         S_WR_HOLD: begin
            // addr wraps to 0 on its own; bank rolls over when addr wraps.
            addr_d  = addr_q + 1'b1;
            bank_d  = wrap_all ? 3'd0 : (last_addr ? bank_q + 3'd1 : bank_q);
            cnt_d   = '0;
            state_d = wrap_all ? S_RD_WAIT : S_WR_SETUP;
         end
         S_RD_WAIT: begin
            if (cnt_q == CNT_W'(WAIT_CYCLES)) begin
               if (ram_data_i != pattern(mode_q, bank_q, addr_q)) begin
                  state_d     = S_DONE;
                  pass_d      = 1'b0;
                  fail_bank_d = bank_q;
                  fail_addr_d = addr_q;
                  fail_data_d = ram_data_i;
               end else if (wrap_all) begin
                  state_d = S_DONE;
                  pass_d  = 1'b1;
               end else begin
                  addr_d = addr_q + 1'b1;
                  bank_d = last_addr ? bank_q + 3'd1 : bank_q;
                  cnt_d  = '0;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Pin values are decoded from the next state so they line up with it.
   assign wr_next = (state_d == S_WR_SETUP) || (state_d == S_WR_PULSE) ||
                    (state_d == S_WR_HOLD);
   assign rd_next = (state_d == S_RD_WAIT);

   always_comb begin
      ram_addr_d    = ADDR_WIDTH'(addr_d);
      ram_data_oe_d = wr_next;
      ram_data_o_d  = wr_next ? pattern(mode_d, bank_d, addr_d) : '0;
      ram_we_n_d    = (state_d != S_WR_PULSE);
      ram_oe_n_d    = !rd_next;
      ram_ce_n_d    = '1;
      for (int i = 0; i < NUM_BANKS; i++) begin
         if ((wr_next || rd_next) && bank_d == 3'(i)) ram_ce_n_d[i] = 1'b0;
      end
   end

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples the pre-edge values, independent of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         bank_q      <= '0;
         addr_q      <= '0;
         cnt_q       <= '0;
         mode_q      <= '0;
         pass        <= 1'b0;
         fail_bank   <= '0;
         fail_addr   <= '0;
         fail_data   <= '0;
         ram_addr    <= '0;
         ram_data_o  <= '0;
         ram_data_oe <= 1'b0;
         ram_ce_n    <= '1;
         ram_oe_n    <= 1'b1;
         ram_we_n    <= 1'b1;
      end else begin
         state_q     <= state_d;
         bank_q      <= bank_d;
         addr_q      <= addr_d;
         cnt_q       <= cnt_d;
         mode_q      <= mode_d;
         pass        <= pass_d;
         fail_bank   <= fail_bank_d;
         fail_addr   <= fail_addr_d;
         fail_data   <= fail_data_d;
         ram_addr    <= ram_addr_d;
         ram_data_o  <= ram_data_o_d;
         ram_data_oe <= ram_data_oe_d;
         ram_ce_n    <= ram_ce_n_d;
         ram_oe_n    <= ram_oe_n_d;
         ram_we_n    <= ram_we_n_d;
      end
   end

   assign busy = (state_q == S_WR_SETUP) || (state_q == S_WR_PULSE) ||
                 (state_q == S_WR_HOLD)  || (state_q == S_RD_WAIT);
   assign done = (state_q == S_DONE);

   always_comb begin
      if (state_q == S_IDLE)
         leds = 16'haaaa;
      else
         leds = {busy, done, pass, (state_q == S_RD_WAIT),
                 12'(busy ? addr_q : fail_addr)};
   end

endmodule

// File: tb/tb_board_mem_tester.sv
// Scoreboarded bench for board_mem_tester with a behavioural SRAM model
// (ideal, stuck-at bit, or bank 1 aliased onto bank 0).
module tb_board_mem_tester;
   localparam int AW    = 20;
   localparam int DW    = 32;
   localparam int NB    = 2;
   localparam int TAW   = 6;
   localparam int WC    = 2;
   localparam int WORDS = 1 << TAW;
   localparam int N     = NB * WORDS;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic [1:0]     mode = 2'd0;
   logic [AW-1:0]  ram_addr;
   logic [DW-1:0]  ram_data_o;
   logic           ram_data_oe;
   logic [DW-1:0]  ram_data_i;
   logic [NB-1:0]  ram_ce_n;
   logic           ram_oe_n;
   logic           ram_we_n;
   logic           busy, done, pass;
   logic [2:0]     fail_bank;
   logic [TAW-1:0] fail_addr;
   logic [DW-1:0]  fail_data;
   logic [15:0]    leds;

   board_mem_tester #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BANKS(NB),
      .TEST_ADDR_WIDTH(TAW), .WAIT_CYCLES(WC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
      .ram_addr(ram_addr), .ram_data_o(ram_data_o), .ram_data_oe(ram_data_oe),
      .ram_data_i(ram_data_i), .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n),
      .ram_we_n(ram_we_n), .busy(busy), .done(done), .pass(pass),
      .fail_bank(fail_bank), .fail_addr(fail_addr), .fail_data(fail_data),
      .leds(leds)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference behaviour ----------------
   function automatic logic [31:0] ref_pat(input int m, input int b, input int a);
      logic [31:0] v;
      case (m)
         0:       v = 32'(a);
         1:       v = (a % 2 == 0) ? 32'h5555_5555 : 32'hAAAA_AAAA;
         2:       v = 32'd1 << (a % 32);
         default: v = ~32'(a);
      endcase
      if (b % 2 == 1) v = ~v;
      return v;
   endfunction

   // fault_kind: 0 ideal, 1 one stuck-at-0 bit, 2 bank 1 aliases bank 0
   int          fault_kind = 0;
   int          stuck_bank = 0, stuck_addr = 0, stuck_bit = 0;
   int          cur_mode = 0;
   logic [31:0] mem [NB][WORDS];

   function automatic int phys(input int b);
      return (fault_kind == 2 && b == 1) ? 0 : b;
   endfunction

   function automatic int sel_bank(input logic [NB-1:0] ce_n);
      for (int b = 0; b < NB; b++) if (!ce_n[b]) return b;
      return -1;
   endfunction

   typedef struct {
      logic        pass;
      int          bank;
      int          addr;
      logic [31:0] data;
      int          latency;
   } exp_t;

   exp_t exp_q[$];
   int   start_cyc = 0;

   // Whole-test outcome: every word written, then read back in order until
   // the first word that differs from what was written to it.
   function automatic exp_t predict(input int m);
      exp_t e;
      int   k = 0;
      for (int b = 0; b < NB; b++) begin
         for (int a = 0; a < WORDS; a++) begin
            logic [31:0] want, got;
            k++;
            want = ref_pat(m, b, a);
            got  = (fault_kind == 2 && b < 2) ? ref_pat(m, 1, a) : want;
            if (fault_kind == 1 && b == stuck_bank && a == stuck_addr)
               got &= ~(32'd1 << stuck_bit);
            if (got != want) begin
               e = '{1'b0, b, a, got, N * (WC + 2) + k * (WC + 1) + 1};
               return e;
            end
         end
      end
      e = '{1'b1, 0, 0, 32'd0, N * (WC + 2) + N * (WC + 1) + 1};
      return e;
   endfunction

   // ---------------- SRAM model ----------------
   always_comb begin
      int b;
      ram_data_i = 32'hDEAD_BEEF;
      b = sel_bank(ram_ce_n);
      if (!ram_oe_n && b >= 0) ram_data_i = mem[phys(b)][ram_addr[TAW-1:0]];
   end

   logic [AW-1:0] prev_addr = '0;
   logic [DW-1:0] prev_data = '0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (busy && $countones(~ram_ce_n) > 1) check("ce_exclusive", $countones(~ram_ce_n), 1);
         if (!ram_we_n) begin
            int b;
            int a;
            logic [31:0] d;
            b = sel_bank(ram_ce_n);
            a = int'(ram_addr[TAW-1:0]);
            check("we_addr_stable", ram_addr, prev_addr);
            check("we_data_stable", ram_data_o, prev_data);
            check("we_data_oe", ram_data_oe, 1'b1);
            check("we_upper_addr", ram_addr >> TAW, 0);
            if (b < 0) begin
               check("we_without_ce", 0, 1);
            end else begin
               check("wr_data", ram_data_o, ref_pat(cur_mode, b, a));
               d = ram_data_o;
               if (fault_kind == 1 && b == stuck_bank && a == stuck_addr)
                  d &= ~(32'd1 << stuck_bit);
               mem[phys(b)][a] = d;
            end
         end
      end
      prev_addr = ram_addr;
      prev_data = ram_data_o;
   end

   // ---------------- scoreboard monitor ----------------
   initial begin
      logic dp = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && done && !dp) begin
            if (exp_q.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("pass", pass, e.pass);
               check("fail_bank", fail_bank, e.bank);
               check("fail_addr", fail_addr, e.addr);
               check("fail_data", fail_data, e.data);
               check("latency", cyc - start_cyc + 1, e.latency);
               check("leds_done", leds, {1'b0, 1'b1, e.pass, 1'b0, 12'(e.addr)});
               check("done_pins", {busy, ram_we_n, ram_oe_n, ram_ce_n, ram_data_oe},
                     {1'b0, 1'b1, 1'b1, {NB{1'b1}}, 1'b0});
            end
         end
         dp = done;
      end
   end

   // ---------------- stimulus ----------------
   task automatic run_test(input int m, input int kind, input int sb, input int sa,
                           input int sbit, input bit pulse_mid);
      int t;
      fault_kind = kind;
      stuck_bank = sb;
      stuck_addr = sa;
      stuck_bit  = sbit;
      for (int b = 0; b < NB; b++)
         for (int a = 0; a < WORDS; a++) mem[b][a] = $urandom;
      @(negedge clk);
      cur_mode = m;
      mode     = 2'(m);
      start    = 1'b1;
      @(posedge clk);
      #1;
      start_cyc = cyc;
      exp_q.push_back(predict(m));
      @(negedge clk);
      start = 1'b0;
      mode  = 2'($urandom);
      check("busy_rise", busy, 1'b1);
      if (pulse_mid) begin
         repeat (37) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      t = 0;
      while (!done && t < 4 * N * (2 * WC + 3)) begin
         @(negedge clk);
         t++;
      end
      if (!done) begin
         check("done_timeout", 0, 1);
         exp_q.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int t;
      #12;
      check("rst_pins", {ram_ce_n, ram_oe_n, ram_we_n, ram_data_oe},
            {{NB{1'b1}}, 1'b1, 1'b1, 1'b0});
      check("rst_addr_data", {ram_addr, ram_data_o}, 0);
      check("rst_status", {busy, done, pass, fail_bank, fail_addr, fail_data}, 0);
      check("rst_leds", leds, 16'haaaa);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run_test(0, 0, 0, 0, 0, 1'b0);   // ideal memory
      run_test(0, 1, 1, 5, 3, 1'b0);   // bank 1 addr 5 bit 3 stuck at 0
      run_test(1, 2, 0, 0, 0, 1'b0);   // bank 1 aliases bank 0
      run_test(2, 0, 0, 0, 0, 1'b0);   // walking one across the DW wrap
      run_test(3, 0, 0, 0, 0, 1'b1);   // start pulsed mid-write is ignored
      for (int i = 0; i < 5; i++)
         run_test($urandom_range(3), $urandom_range(2), $urandom_range(NB - 1),
                  $urandom_range(WORDS - 1), $urandom_range(31), 1'b0);

      // Reset during a write pulse aborts at once.
      fault_kind = 0;
      @(negedge clk);
      cur_mode = 0;
      mode     = 2'd0;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      t = 0;
      while (ram_we_n && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("reached_wr_pulse", ram_we_n, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("abort_we_n", ram_we_n, 1'b1);
      check("abort_ce_n", ram_ce_n, {NB{1'b1}});
      check("abort_busy", {busy, done}, 2'b00);
      check("abort_leds", leds, 16'haaaa);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run_test(0, 0, 0, 0, 0, 1'b0);   // recovery after abort
      check("scoreboard_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
